// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared register map and field layout for the interrupt
// controller. Imported by int_ctrl and by anything that decodes its
// register space.
package int_ctrl_pkg;

  // Register indices on the 2-bit addr bus.
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CURRENT = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_GEN_BIT   = 0;  // global enable (RW)
  localparam int CTRL_INSVC_BIT = 1;  // in_service (RO); write 1 = abort

  // CURRENT layout.
  localparam int CUR_VALID_BIT = 31;
  localparam int CUR_ID_W      = 4;

  // In-service descriptor held in CURRENT.
  typedef struct packed {
    logic                valid;
    logic [CUR_ID_W-1:0] id;
  } cur_t;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-first priority encoder.
//   req : NUM_IRQ request bits
//   id  : index of the lowest set bit (0 when none set)
//   vld : at least one request bit set
module int_prio_enc #(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [3:0]         id,
  output logic               vld
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    id  = '0;
    vld = |req;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered interrupt controller with a 4-register CPU port.
//   clk, rst      : clock, asynchronous active-low reset
//   irq_in        : source lines, each rising edge latches a pending request
//   irq           : registered request to the CPU
//   intack, rti   : CPU acknowledge / return-from-interrupt strobes
//   intabort      : one-cycle abort pulse, fired by writing CTRL bit1
//   io_en, rd, wr : device select and access strobes
//   addr, data_in : register index and write data
//   data_out      : combinational read data, zero unless io_en & rd
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  input  logic               intack,
  input  logic               rti,
  output logic               intabort,
  input  logic               io_en,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out
);

  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic               gen_q, gen_d;
  logic               insvc_q, insvc_d;
  cur_t               cur_q, cur_d;
  logic               irq_q, irq_d;
  logic               intabort_q, intabort_d;
  // Low for the first cycle after reset so the edge copy can load the live
  // irq_in level without that level reading as a rising edge.
  logic               armed_q, armed_d;

  logic [NUM_IRQ-1:0] edge_s, eligible, pend_clr, one_hot;
  logic [3:0]         sel_id;
  logic               sel_vld, wr_en, rd_en, abort;

  // Upper write-data bits have no home in any register.
  logic               unused_data;
  assign unused_data = ^data_in[31:NUM_IRQ];

  assign wr_en    = io_en & wr;
  assign rd_en    = io_en & rd;
  assign eligible = pending_q & enable_q;

  int_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req (eligible),
    .id  (sel_id),
    .vld (sel_vld)
  );

  assign one_hot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << sel_id;

  always_comb begin
    edge_s     = armed_q ? (irq_in & ~irq_prev_q) : '0;
    irq_prev_d = irq_in;
    armed_d    = 1'b1;
    enable_d   = enable_q;
    gen_d      = gen_q;
    pend_clr   = '0;
    abort      = 1'b0;
    insvc_d    = insvc_q;
    cur_d      = cur_q;

    if (wr_en) begin
      case (addr)
        ADDR_ENABLE:  enable_d = data_in[NUM_IRQ-1:0];
        ADDR_PENDING: pend_clr = data_in[NUM_IRQ-1:0];
        ADDR_CTRL: begin
          gen_d = data_in[CTRL_GEN_BIT];
          abort = data_in[CTRL_INSVC_BIT];
        end
        default: ;  // CURRENT is read-only
      endcase
    end

    // rti and intack are mutually exclusive through insvc_q; an abort in
    // the same cycle as an intack drops the acknowledge.
    if (abort || (rti && insvc_q)) begin
      insvc_d = 1'b0;
      cur_d   = '0;
    end else if (intack && !insvc_q) begin
      insvc_d   = 1'b1;
      cur_d.valid = sel_vld;
      cur_d.id    = sel_vld ? sel_id : 4'd0;
      if (sel_vld) pend_clr = pend_clr | one_hot;
    end

    // A new edge beats any clear in the same cycle.
    pending_d  = (pending_q & ~pend_clr) | edge_s;
    irq_d      = gen_q & ~insvc_q & (|eligible);
    intabort_d = abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      gen_q      <= 1'b0;
      insvc_q    <= 1'b0;
      cur_q      <= '0;
      irq_q      <= 1'b0;
      intabort_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      gen_q      <= gen_d;
      insvc_q    <= insvc_d;
      cur_q      <= cur_d;
      irq_q      <= irq_d;
      intabort_q <= intabort_d;
      armed_q    <= armed_d;
    end
  end

  assign irq      = irq_q;
  assign intabort = intabort_q;

  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_ENABLE:  data_out[NUM_IRQ-1:0] = enable_q;
        ADDR_PENDING: data_out[NUM_IRQ-1:0] = pending_q;
        ADDR_CURRENT: begin
          data_out[CUR_VALID_BIT]  = cur_q.valid;
          data_out[CUR_ID_W-1:0]   = cur_q.id;
        end
        default: begin
          data_out[CTRL_GEN_BIT]   = gen_q;
          data_out[CTRL_INSVC_BIT] = insvc_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scoreboard bench for int_ctrl. Each read pushes the
// expected {data_out, irq, intabort}; the monitor pops on every io_en & rd
// cycle and compares at the falling edge.
module tb_int_ctrl;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          irq, intack, rti, intabort;
  logic          io_en, rd, wr;
  logic [1:0]    addr;
  logic [31:0]   data_in, data_out;

  int_ctrl #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq(irq), .intack(intack),
    .rti(rti), .intabort(intabort), .io_en(io_en), .rd(rd), .wr(wr),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        irq;
    logic        ab;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    if (io_en && rd) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: got data=%h irq=%b intabort=%b, no expected entry",
                 data_out, irq, intabort);
      end else begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (data_out !== e.d || irq !== e.irq || intabort !== e.ab) begin
          miscompares++;
          $display("FAIL %s: got data=%h irq=%b intabort=%b, expected data=%h irq=%b intabort=%b",
                   e.name, data_out, irq, intabort, e.d, e.irq, e.ab);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    io_en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    cyc();
    io_en = 1'b0; wr = 1'b0; data_in = '0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] d,
                        input logic ei, input logic ea, input string nm);
    exp_t e;
    e.d = d; e.irq = ei; e.ab = ea; e.name = nm;
    q.push_back(e);
    io_en = 1'b1; rd = 1'b1; addr = a;
    cyc();
    io_en = 1'b0; rd = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = irq_in | m;
    cyc();
    irq_in = irq_in & ~m;
  endtask

  task automatic ack();
    intack = 1'b1; cyc(); intack = 1'b0;
  endtask

  task automatic ret();
    rti = 1'b1; cyc(); rti = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; intack = 0; rti = 0;
    io_en = 0; rd = 0; wr = 0; addr = '0; data_in = '0;
    cyc(2);
    rd_chk(2'd1, 32'h0, 0, 0, "reset_pending");
    rd_chk(2'd3, 32'h0, 0, 0, "reset_ctrl");
    rst = 1'b1;
    cyc();

    // Single source served and retired.
    wr_reg(2'd0, 32'h0000_0005);
    wr_reg(2'd3, 32'h0000_0001);
    rd_chk(2'd0, 32'h0000_0005, 0, 0, "enable_rb");
    pulse(16'h0004);
    cyc();
    rd_chk(2'd1, 32'h0000_0004, 1, 0, "t1_pending_irq");
    ack();
    cyc();
    rd_chk(2'd2, 32'h8000_0002, 0, 0, "t1_current");
    rd_chk(2'd1, 32'h0, 0, 0, "t1_pending_cleared");
    ret();
    rd_chk(2'd2, 32'h0, 0, 0, "t1_current_after_rti");
    rd_chk(2'd3, 32'h1, 0, 0, "t1_ctrl_after_rti");

    // Two simultaneous sources: lowest index first.
    pulse(16'h0005);
    cyc();
    rd_chk(2'd1, 32'h0000_0005, 1, 0, "t2_pending_both");
    ack();
    cyc();
    rd_chk(2'd2, 32'h8000_0000, 0, 0, "t2_first_id0");
    rd_chk(2'd1, 32'h0000_0004, 0, 0, "t2_pending_left");
    rd_chk(2'd3, 32'h3, 0, 0, "t2_irq_low_in_service");
    ret();
    rd_chk(2'd3, 32'h1, 0, 0, "t2_irq_low_rti_cycle");
    rd_chk(2'd1, 32'h0000_0004, 1, 0, "t2_irq_after_rti");
    ack();
    cyc();
    rd_chk(2'd2, 32'h8000_0002, 0, 0, "t2_second_id2");
    ret();

    // Masked source, unmask, then write-1-clear.
    wr_reg(2'd0, 32'h0);
    pulse(16'h0008);
    cyc();
    rd_chk(2'd1, 32'h0000_0008, 0, 0, "t3_masked_pending");
    wr_reg(2'd0, 32'h0000_0008);
    cyc();
    rd_chk(2'd0, 32'h0000_0008, 1, 0, "t3_unmask_irq");
    wr_reg(2'd1, 32'h0000_0008);
    cyc();
    rd_chk(2'd1, 32'h0, 0, 0, "t3_w1c");

    // Edge coinciding with the acknowledge that clears it.
    wr_reg(2'd0, 32'h0000_0002);
    pulse(16'h0002);
    cyc();
    rd_chk(2'd1, 32'h0000_0002, 1, 0, "t4_pending");
    irq_in[1] = 1'b1; intack = 1'b1;
    cyc();
    irq_in[1] = 1'b0; intack = 1'b0;
    cyc();
    rd_chk(2'd2, 32'h8000_0001, 0, 0, "t4_current");
    rd_chk(2'd1, 32'h0000_0002, 0, 0, "t4_set_wins");
    ret();
    cyc();
    rd_chk(2'd1, 32'h0000_0002, 1, 0, "t4_irq_reraised");

    // Abort while in service, then spurious acknowledge.
    ack();
    cyc();
    pulse(16'h0002);
    rd_chk(2'd1, 32'h0000_0002, 0, 0, "t5_pending_in_service");
    rd_chk(2'd3, 32'h3, 0, 0, "t5_ctrl_in_service");
    wr_reg(2'd3, 32'h0000_0003);
    rd_chk(2'd3, 32'h1, 0, 1, "t5_abort_pulse");
    rd_chk(2'd1, 32'h0000_0002, 1, 0, "t5_abort_once_irq_back");
    rd_chk(2'd2, 32'h0, 1, 0, "t5_current_cleared");
    wr_reg(2'd1, 32'h0000_0002);
    ack();
    cyc();
    rd_chk(2'd2, 32'h0, 0, 0, "t5_spurious_current");
    rd_chk(2'd3, 32'h3, 0, 0, "t5_spurious_in_service");
    rd_chk(2'd1, 32'h0, 0, 0, "t5_spurious_pending");

    // Reset mid-service with sources held high across release.
    irq_in = 16'h000F;
    rst = 1'b0;
    #1;
    rd_chk(2'd3, 32'h0, 0, 0, "t6_reset_ctrl");
    rd_chk(2'd0, 32'h0, 0, 0, "t6_reset_enable");
    rst = 1'b1;
    cyc(2);
    rd_chk(2'd1, 32'h0, 0, 0, "t6_no_pending_after_release");
    wr_reg(2'd0, 32'h0000_000F);
    wr_reg(2'd3, 32'h0000_0001);
    cyc();
    rd_chk(2'd1, 32'h0, 0, 0, "t6_still_idle");
    irq_in = '0;
    cyc();
    pulse(16'h0001);
    cyc();
    rd_chk(2'd1, 32'h0000_0001, 1, 0, "t6_edge_after_reset");

    cyc(2);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
